// File: rtl/down_timer.sv
// down_timer
// ----------
// Loadable down-counting timer with a start / pause / done handshake.
// A value is loaded, counting is started, and the block counts toward zero.
// On expiry it raises a one-cycle done pulse. In one-shot mode
// (AUTO_RELOAD = 0) it then parks in EXPIRED. In periodic mode
// (AUTO_RELOAD = 1) it restarts from the reload register.
//
// Parameters
//   N            width of count / load_value
//   AUTO_RELOAD  1 = periodic (reload on expiry), 0 = one-shot
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high reset (highest priority)
//   load          in   capture load_value into reload register and count
//   load_value    in   [N-1:0] value to load
//   start         in   begin / resume counting (level-sensitive)
//   pause         in   freeze counting; wins over a simultaneous start
//   count         out  [N-1:0] current timer value (registered)
//   running       out  high while in RUN (registered)
//   done          out  one-cycle expiry pulse (registered)
//   expire_count  out  [7:0] done pulses since reset/load, saturating at 255
//
// Input priority per edge: reset > load > pause > start.

module down_timer #(
  parameter int unsigned N           = 8,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] count,
  output logic         running,
  output logic         done,
  output logic [7:0]   expire_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [N-1:0] CNT_ZERO = '0;
  localparam logic [N-1:0] CNT_ONE  = N'(1);
  localparam logic [7:0]   EXP_MAX  = '1;

  state_t       state_q,   state_d;
  logic [N-1:0] count_q,   count_d;
  logic [N-1:0] reload_q,  reload_d;
  logic         running_q, running_d;
  logic         done_q,    done_d;
  logic [7:0]   expire_q,  expire_d;

  // Set on every edge that raises done; the counter update keys off it so
  // the saturation rule lives in one place.
  logic         fire;

  // ------------------------------------------------------------------
  // Next-state / output logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = expire_q;
    fire     = 1'b0;

    if (load) begin
      // Load aborts whatever is in progress and never raises done.
      reload_d = load_value;
      count_d  = load_value;
      expire_d = '0;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_EXPIRED: begin
          if (!pause && start) begin
            if (count_q != CNT_ZERO) begin
              // Count holds on this edge; first decrement on the next one.
              state_d = ST_RUN;
            end else begin
              // Zero-length timeout: expire immediately.
              state_d = ST_EXPIRED;
              fire    = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else if (count_q == CNT_ONE) begin
            fire = 1'b1;
            if (AUTO_RELOAD) begin
              count_d = reload_q;
            end else begin
              count_d = CNT_ZERO;
              state_d = ST_EXPIRED;
            end
          end else begin
            // RUN is never entered with a zero count; park safely if it is.
            state_d = ST_EXPIRED;
          end
        end

        ST_PAUSED: begin
          if (!pause && start) begin
            state_d = ST_RUN;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (fire && (expire_q != EXP_MAX)) begin
      expire_d = expire_q + 8'd1;
    end

    done_d    = fire;
    running_d = (state_d == ST_RUN);
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expire_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
      expire_q  <= expire_d;
    end
  end

  assign count        = count_q;
  assign running      = running_q;
  assign done         = done_q;
  assign expire_count = expire_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: one one-shot instance and one periodic
// instance driven by the same stimulus.
module tb_down_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  logic [7:0] os_count, ar_count;
  logic       os_running, ar_running;
  logic       os_done, ar_done;
  logic [7:0] os_exp, ar_exp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  down_timer #(.N(8), .AUTO_RELOAD(1'b0)) u_os (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(os_count), .running(os_running),
    .done(os_done), .expire_count(os_exp)
  );

  down_timer #(.N(8), .AUTO_RELOAD(1'b1)) u_ar (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(ar_count), .running(ar_running),
    .done(ar_done), .expire_count(ar_exp)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_os(input string tag, input logic [7:0] c, input logic r,
                        input logic d, input logic [7:0] e);
    chk({tag, ".os_count"},   32'(os_count),   32'(c));
    chk({tag, ".os_running"}, 32'(os_running), 32'(r));
    chk({tag, ".os_done"},    32'(os_done),    32'(d));
    chk({tag, ".os_exp"},     32'(os_exp),     32'(e));
  endtask

  task automatic chk_ar(input string tag, input logic [7:0] c, input logic r,
                        input logic d, input logic [7:0] e);
    chk({tag, ".ar_count"},   32'(ar_count),   32'(c));
    chk({tag, ".ar_running"}, 32'(ar_running), 32'(r));
    chk({tag, ".ar_done"},    32'(ar_done),    32'(d));
    chk({tag, ".ar_exp"},     32'(ar_exp),     32'(e));
  endtask

  initial begin
    // ---------------- reset then idle ----------------
    reset = 1'b1;
    tick(); tick();
    chk_os("rst", 8'd0, 1'b0, 1'b0, 8'd0);
    chk_ar("rst", 8'd0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_os("idle", 8'd0, 1'b0, 1'b0, 8'd0);
    end

    // ---------------- one-shot, load 3 ----------------
    load_value = 8'd3; load = 1'b1;
    tick();
    load = 1'b0;
    chk_os("os_load", 8'd3, 1'b0, 1'b0, 8'd0);
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    chk_os("os_k0", 8'd3, 1'b1, 1'b0, 8'd0);
    tick();
    chk_os("os_k1", 8'd2, 1'b1, 1'b0, 8'd0);
    tick();
    chk_os("os_k2", 8'd1, 1'b1, 1'b0, 8'd0);
    tick();
    chk_os("os_k3", 8'd0, 1'b0, 1'b1, 8'd1);
    chk_ar("ar_k3", 8'd3, 1'b1, 1'b1, 8'd1);
    tick();
    chk_os("os_k4", 8'd0, 1'b0, 1'b0, 8'd1);

    // ---------------- pause / resume, load 5 ----------------
    load_value = 8'd5; load = 1'b1;
    tick();
    load = 1'b0;
    chk_os("pr_load", 8'd5, 1'b0, 1'b0, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_os("pr_start", 8'd5, 1'b1, 1'b0, 8'd0);
    tick(); tick();
    chk_os("pr_at3", 8'd3, 1'b1, 1'b0, 8'd0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_os("pr_pause", 8'd3, 1'b0, 1'b0, 8'd0);
    end
    start = 1'b1;                 // pause + start together: stays PAUSED
    tick();
    chk_os("pr_pause_start", 8'd3, 1'b0, 1'b0, 8'd0);
    pause = 1'b0;
    tick();                       // resume edge, count holds
    start = 1'b0;
    chk_os("pr_resume", 8'd3, 1'b1, 1'b0, 8'd0);
    tick();
    chk_os("pr_2", 8'd2, 1'b1, 1'b0, 8'd0);
    tick();
    chk_os("pr_1", 8'd1, 1'b1, 1'b0, 8'd0);
    tick();
    chk_os("pr_0", 8'd0, 1'b0, 1'b1, 8'd1);
    tick();
    chk_os("pr_after", 8'd0, 1'b0, 1'b0, 8'd1);

    // ---------------- periodic, load 4 ----------------
    load_value = 8'd4; load = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_ar("per_start", 8'd4, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("per_count", 32'(ar_count), (i % 4 == 0) ? 32'd4 : 32'(4 - (i % 4)));
      chk("per_done",  32'(ar_done),  (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    chk_ar("per_end", 8'd4, 1'b1, 1'b1, 8'd5);

    // ---------------- periodic, reload 1: saturation ----------------
    load_value = 8'd1; load = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_ar("r1_start", 8'd1, 1'b1, 1'b0, 8'd0);
    tick();
    chk_ar("r1_first", 8'd1, 1'b1, 1'b1, 8'd1);
    for (int i = 2; i <= 300; i++) tick();
    chk_ar("r1_sat", 8'd1, 1'b1, 1'b1, 8'd255);
    chk_os("r1_os", 8'd0, 1'b0, 1'b0, 8'd1);

    // ---------------- load 0 then start ----------------
    load_value = 8'd0; load = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_os("z_start", 8'd0, 1'b0, 1'b1, 8'd1);
    tick();
    chk_os("z_after", 8'd0, 1'b0, 1'b0, 8'd1);
    start = 1'b1;                 // re-arm from EXPIRED with zero count
    tick();
    start = 1'b0;
    chk_os("z_rearm", 8'd0, 1'b0, 1'b1, 8'd2);

    // ---------------- load abort mid-run ----------------
    load_value = 8'd5; load = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk_os("ab_at2", 8'd2, 1'b1, 1'b0, 8'd0);
    load_value = 8'd9; load = 1'b1;
    tick();
    load = 1'b0;
    chk_os("ab_load", 8'd9, 1'b0, 1'b0, 8'd0);
    tick(); tick();
    chk_os("ab_hold", 8'd9, 1'b0, 1'b0, 8'd0);

    // ---------------- reset mid-run ----------------
    load_value = 8'd8; load = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_os("rr_at6", 8'd6, 1'b1, 1'b0, 8'd0);
    reset = 1'b1;
    start = 1'b1;                 // reset wins over start
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_os("rr_reset", 8'd0, 1'b0, 1'b0, 8'd0);
    chk_ar("rr_reset", 8'd0, 1'b0, 1'b0, 8'd0);
    start = 1'b1;                 // reload register cleared too: zero timeout
    tick();
    start = 1'b0;
    chk_os("rr_zero", 8'd0, 1'b0, 1'b1, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
